// File: rtl/adh_seq_if.sv
// Handshake and address-high select bundle for the adh_seq sequencer.
interface adh_seq_if;
  logic       req;
  logic [2:0] mode;
  logic       rdy;
  logic       page_carry;
  logic       ack;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] adh_sel;
  logic [2:0] cyc;

  modport master (
    output req, mode, rdy, page_carry,
    input  ack, busy, done, err, adh_sel, cyc
  );

  modport slave (
    input  req, mode, rdy, page_carry,
    output ack, busy, done, err, adh_sel, cyc
  );
endinterface

// File: rtl/adh_seq.sv
// Address-high sequencer: walks the cycle sequence for each addressing mode
// and drives a registered select for the high address mux.
// Optional feature: ADH_SEQ_PAGE_FIX_EN adds the page-cross FIX cycle for
// indexed modes 3 and 5; without it page_carry is ignored.
module adh_seq (
  input logic       clk,
  input logic       reset_n,
  adh_seq_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, F1, F2, STK, P1, P2, EA, FIX} state_t;

`ifdef ADH_SEQ_PAGE_FIX_EN
  localparam bit PAGE_FIX = 1'b1;
`else
  localparam bit PAGE_FIX = 1'b0;
`endif

  state_t     state, state_nx;
  logic [2:0] mode_q;
  logic [2:0] mode_eff;
  logic [2:0] cyc_q;
  logic [3:0] sel_q;
  logic       ack_q;
  logic       accept;
  logic       last;
  logic       fix_req;

  // Select code for a given state; mode picks the source in EA/P1/P2.
  function automatic logic [3:0] sel_for(input state_t s, input logic [2:0] m);
    logic [3:0] r;
    r = 4'b0000;
    case (s)
      STK:     r = 4'b0001;
      EA:      r = (m == 3'd1) ? 4'b0010 : ((m == 3'd4) ? 4'b1000 : 4'b0100);
      FIX:     r = 4'b1000;
      P1, P2:  r = (m == 3'd4) ? 4'b0100 : 4'b0010;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Mode is not yet captured in the accepting cycle, so use the live input there.
  always_comb mode_eff = (state == IDLE) ? bus.mode : mode_q;

  // Page-cross fix applies only to the indexed modes.
  always_comb fix_req = PAGE_FIX && ((mode_q == 3'd3) || (mode_q == 3'd5)) && bus.page_carry;

  // Next-state decode; last marks the final sequence cycle regardless of rdy.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          accept   = 1'b1;
          state_nx = (bus.mode == 3'd2) ? STK : F1;
        end
      end
      F1: begin
        case (mode_q)
          3'd0, 3'd3, 3'd4: state_nx = F2;
          3'd1:             state_nx = EA;
          3'd5:             state_nx = P1;
          default: begin
            state_nx = IDLE;
            last     = 1'b1;
          end
        endcase
      end
      F2:  state_nx = (mode_q == 3'd4) ? P1 : EA;
      STK: begin
        state_nx = IDLE;
        last     = 1'b1;
      end
      P1:  state_nx = P2;
      P2:  state_nx = EA;
      EA: begin
        if (fix_req) begin
          state_nx = FIX;
        end else begin
          state_nx = IDLE;
          last     = 1'b1;
        end
      end
      FIX: begin
        state_nx = IDLE;
        last     = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    if (!bus.rdy) begin
      state_nx = state;
      accept   = 1'b0;
    end
  end

  // State, select, cycle counter, captured mode and ack pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      mode_q <= '0;
      cyc_q  <= '0;
      sel_q  <= '0;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= accept;
      state <= state_nx;
      if (accept) mode_q <= bus.mode;
      if (bus.rdy) begin
        sel_q <= sel_for(state_nx, mode_eff);
        if ((state == IDLE) || (state_nx == IDLE)) cyc_q <= '0;
        else if (cyc_q != 3'd7)                    cyc_q <= cyc_q + 3'd1;
      end
    end
  end

  assign bus.ack     = ack_q;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = last & bus.rdy;
  assign bus.err     = last & bus.rdy & (mode_q[2:1] == 2'b11);
  assign bus.adh_sel = sel_q;
  assign bus.cyc     = cyc_q;

endmodule

// File: tb/tb_adh_seq.sv
// Table-driven bench for adh_seq: each row gives one cycle's inputs and the
// outputs expected in that same cycle.
module tb_adh_seq;

  typedef struct {
    logic        req;
    logic [2:0]  mode;
    logic        rdy;
    logic        pc;
    logic [10:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  adh_seq_if bus();

  adh_seq dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  vec_t        vecs[$];
  logic [10:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [10:0] pk(input logic ack, input logic busy, input logic done,
                                     input logic err, input logic [3:0] sel, input logic [2:0] cyc);
    return {ack, busy, done, err, sel, cyc};
  endfunction

  task automatic v(input logic req, input logic [2:0] mode, input logic rdy, input logic pc,
                   input logic ack, input logic busy, input logic done, input logic err,
                   input logic [3:0] sel, input logic [2:0] cyc);
    vec_t t;
    t.req = req; t.mode = mode; t.rdy = rdy; t.pc = pc;
    t.exp = pk(ack, busy, done, err, sel, cyc);
    vecs.push_back(t);
  endtask

  // Idle row helper: outputs all quiet.
  task automatic vi(input logic req, input logic [2:0] mode);
    v(req, mode, 1'b1, 1'b0, 0, 0, 0, 0, 4'b0000, 3'd0);
  endtask

  task automatic check(input string name);
    logic [10:0] got, want;
    got  = {bus.ack, bus.busy, bus.done, bus.err, bus.adh_sel, bus.cyc};
    want = exp_q.pop_front();
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got ack=%b busy=%b done=%b err=%b sel=%b cyc=%0d, want ack=%b busy=%b done=%b err=%b sel=%b cyc=%0d",
               name, got[10], got[9], got[8], got[7], got[6:3], got[2:0],
               want[10], want[9], want[8], want[7], want[6:3], want[2:0]);
    end
  endtask

  task automatic apply(input int unsigned lo, input int unsigned hi);
    for (int unsigned i = lo; i < hi; i++) begin
      bus.req        = vecs[i].req;
      bus.mode       = vecs[i].mode;
      bus.rdy        = vecs[i].rdy;
      bus.page_carry = vecs[i].pc;
      exp_q.push_back(vecs[i].exp);
      #3;
      check($sformatf("vec%0d", i));
      @(posedge clk);
      #1;
    end
  endtask

  int unsigned seg_a, seg_b, seg_c;

  initial begin
    reset_n        = 1'b0;
    bus.req        = 1'b1;
    bus.mode       = 3'd4;
    bus.rdy        = 1'b1;
    bus.page_carry = 1'b0;

    // ---- segment A: main sequences ----
    // mode 0 ABS
    vi(1, 0);
    v(0,0,1,0, 1,1,0,0, 4'b0000,0);
    v(0,0,1,0, 0,1,0,0, 4'b0000,1);
    v(0,0,1,0, 0,1,1,0, 4'b0100,2);
    vi(0, 0);
    // mode 1 ZP with a stall in EA
    vi(1, 1);
    v(0,1,1,0, 1,1,0,0, 4'b0000,0);
    v(0,1,0,0, 0,1,0,0, 4'b0010,1);
    v(0,1,1,0, 0,1,1,0, 4'b0010,1);
    vi(0, 0);
    // mode 2 STACK
    vi(1, 2);
    v(0,2,1,0, 1,1,1,0, 4'b0001,0);
    vi(0, 0);
    // mode 3 no carry
    vi(1, 3);
    v(0,3,1,0, 1,1,0,0, 4'b0000,0);
    v(0,3,1,0, 0,1,0,0, 4'b0000,1);
    v(0,3,1,0, 0,1,1,0, 4'b0100,2);
    vi(0, 0);
    // mode 3 with carry
    vi(1, 3);
    v(0,3,1,0, 1,1,0,0, 4'b0000,0);
    v(0,3,1,0, 0,1,0,0, 4'b0000,1);
`ifdef ADH_SEQ_PAGE_FIX_EN
    v(0,3,1,1, 0,1,0,0, 4'b0100,2);
    v(0,3,1,0, 0,1,1,0, 4'b1000,3);
`else
    v(0,3,1,1, 0,1,1,0, 4'b0100,2);
`endif
    vi(0, 0);
    // mode 4 IND, carry in EA has no effect
    vi(1, 4);
    v(0,4,1,0, 1,1,0,0, 4'b0000,0);
    v(0,4,1,0, 0,1,0,0, 4'b0000,1);
    v(0,4,1,0, 0,1,0,0, 4'b0100,2);
    v(0,4,1,0, 0,1,0,0, 4'b0100,3);
    v(0,4,1,1, 0,1,1,0, 4'b1000,4);
    vi(0, 0);
    // mode 5 with two stall cycles in P1
    vi(1, 5);
    v(0,5,1,0, 1,1,0,0, 4'b0000,0);
    v(0,5,0,0, 0,1,0,0, 4'b0010,1);
    v(0,5,0,0, 0,1,0,0, 4'b0010,1);
    v(0,5,1,0, 0,1,0,0, 4'b0010,1);
    v(0,5,1,0, 0,1,0,0, 4'b0010,2);
    v(0,5,1,0, 0,1,1,0, 4'b0100,3);
    vi(0, 0);
    // mode 5: carry seen only while stalled must be ignored
    vi(1, 5);
    v(0,5,1,0, 1,1,0,0, 4'b0000,0);
    v(0,5,1,0, 0,1,0,0, 4'b0010,1);
    v(0,5,1,0, 0,1,0,0, 4'b0010,2);
    v(0,5,0,1, 0,1,0,0, 4'b0100,3);
    v(0,5,1,0, 0,1,1,0, 4'b0100,3);
    vi(0, 0);
    // mode 5 with carry
    vi(1, 5);
    v(0,5,1,0, 1,1,0,0, 4'b0000,0);
    v(0,5,1,0, 0,1,0,0, 4'b0010,1);
    v(0,5,1,0, 0,1,0,0, 4'b0010,2);
`ifdef ADH_SEQ_PAGE_FIX_EN
    v(0,5,1,1, 0,1,0,0, 4'b0100,3);
    v(0,5,1,0, 0,1,1,0, 4'b1000,4);
`else
    v(0,5,1,1, 0,1,1,0, 4'b0100,3);
`endif
    vi(0, 0);
    // mode 7 with req held: re-accepted after one idle cycle
    vi(1, 7);
    v(1,7,1,0, 1,1,1,1, 4'b0000,0);
    vi(1, 7);
    v(1,7,1,0, 1,1,1,1, 4'b0000,0);
    vi(0, 0);
    // mode 6
    vi(1, 6);
    v(0,6,1,0, 1,1,1,1, 4'b0000,0);
    vi(0, 0);
    // mode 2 with req held throughout
    vi(1, 2);
    v(1,2,1,0, 1,1,1,0, 4'b0001,0);
    vi(1, 2);
    v(1,2,1,0, 1,1,1,0, 4'b0001,0);
    vi(0, 0);
    // req and mode wiggling while busy are ignored
    vi(1, 0);
    v(1,2,1,0, 1,1,0,0, 4'b0000,0);
    v(1,7,1,0, 0,1,0,0, 4'b0000,1);
    v(1,6,1,0, 0,1,1,0, 4'b0100,2);
    vi(0, 0);
    seg_a = vecs.size();
    // ---- segment B: mode 4 up to P1, reset lands in P2 ----
    vi(1, 4);
    v(0,4,1,0, 1,1,0,0, 4'b0000,0);
    v(0,4,1,0, 0,1,0,0, 4'b0000,1);
    v(0,4,1,0, 0,1,0,0, 4'b0100,2);
    seg_b = vecs.size();
    // ---- segment C: mode 1 straight after reset ----
    vi(1, 1);
    v(0,1,1,0, 1,1,0,0, 4'b0000,0);
    v(0,1,1,0, 0,1,1,0, 4'b0010,1);
    vi(0, 0);
    seg_c = vecs.size();

    // Reset state with req asserted must stay quiet.
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('0);
    check("reset_state");

    reset_n = 1'b1;
    apply(0, seg_a);
    apply(seg_a, seg_b);

    // Now in P2 of mode 4; assert reset mid-cycle.
    #1;
    exp_q.push_back(pk(0, 1, 0, 0, 4'b0100, 3));
    check("in_p2");
    #1;
    bus.req  = 1'b1;
    bus.mode = 3'd1;
    reset_n  = 1'b0;
    #1;
    exp_q.push_back('0);
    check("async_reset");
    @(posedge clk);
    #1;
    exp_q.push_back('0);
    check("reset_hold");
    reset_n = 1'b1;
    apply(seg_b, seg_c);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
